// File: rtl/parking_gate_if.sv
// parking_gate_if: keypad, user-answer, database status and control signals of the parking gate controller
interface parking_gate_if;
  logic       id_submit;
  logic [1:0] mode_sel;
  logic       floor_choice;
  logic       user_accept;
  logic       user_reject;
  logic       id_valid;
  logic       id_special;
  logic       adminId_valid;
  logic       chosen_flr_full;
  logic       alternative_flr_full;
  logic [1:0] MODE;
  logic [1:0] action_taken;
  logic       chosen_flr;
  logic       gate_open;
  logic       deny;
  logic       offer_alt;
  logic       locked;
  logic       busy;
  logic [2:0] result;
  modport master (
    output id_submit, mode_sel, floor_choice, user_accept, user_reject,
           id_valid, id_special, adminId_valid, chosen_flr_full, alternative_flr_full,
    input  MODE, action_taken, chosen_flr, gate_open, deny, offer_alt, locked, busy, result
  );
  modport slave (
    input  id_submit, mode_sel, floor_choice, user_accept, user_reject,
           id_valid, id_special, adminId_valid, chosen_flr_full, alternative_flr_full,
    output MODE, action_taken, chosen_flr, gate_open, deny, offer_alt, locked, busy, result
  );
endinterface

// File: rtl/parking_gate_controller.sv
// parking_gate_controller: sequences one database commit per accepted ID, runs gate, offer, deny and lockout
module parking_gate_controller #(
  parameter int GATE_CYCLES   = 8,
  parameter int OFFER_TIMEOUT = 16,
  parameter int DENY_CYCLES   = 4,
  parameter int MAX_FAILS     = 3
) (
  input logic           CLK,
  input logic           RST_N,
  parking_gate_if.slave bus
);
  localparam int TMAX = (GATE_CYCLES > OFFER_TIMEOUT ? GATE_CYCLES : OFFER_TIMEOUT) > DENY_CYCLES ?
                        (GATE_CYCLES > OFFER_TIMEOUT ? GATE_CYCLES : OFFER_TIMEOUT) : DENY_CYCLES;
  localparam int TW = TMAX > 1 ? $clog2(TMAX) : 1;
  localparam int FW = $clog2(MAX_FAILS + 1);
  typedef enum logic [2:0] {IDLE, CHECK, OFFER, COMMIT, GATE, DENY} state_t;
  state_t        state;
  logic [TW-1:0] timer;
  logic [FW-1:0] fail_cnt;
  logic [FW-1:0] fail_nxt;
  assign fail_nxt = fail_cnt == FW'(MAX_FAILS) ? fail_cnt : fail_cnt + FW'(1);
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state            <= IDLE;
      timer            <= '0;
      fail_cnt         <= '0;
      bus.MODE         <= '0;
      bus.action_taken <= '0;
      bus.chosen_flr   <= 1'b0;
      bus.gate_open    <= 1'b0;
      bus.deny         <= 1'b0;
      bus.offer_alt    <= 1'b0;
      bus.locked       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.result       <= '0;
    end else begin
      timer <= '0;
      case (state)
        IDLE: if (bus.id_submit) begin
          bus.MODE       <= bus.mode_sel;
          bus.chosen_flr <= bus.floor_choice;
          bus.busy       <= 1'b1;
          state          <= CHECK;
        end
        CHECK: begin
          if (bus.adminId_valid) begin
            bus.locked    <= 1'b0;
            fail_cnt      <= '0;
            bus.gate_open <= 1'b1;
            state         <= GATE;
          end else if (bus.locked || bus.MODE == 2'd2) begin
            bus.result <= bus.locked ? 3'd6 : 3'd5;
            bus.deny   <= 1'b1;
            state      <= DENY;
          end else if (bus.MODE == 2'd0 && bus.id_special) begin
            bus.chosen_flr   <= 1'b0;
            bus.action_taken <= 2'd2;
            state            <= COMMIT;
          end else if (bus.MODE == 2'd0 && bus.id_valid) begin
            if (!bus.chosen_flr_full) begin
              bus.action_taken <= 2'd2;
              state            <= COMMIT;
            end else if (!bus.alternative_flr_full) begin
              bus.offer_alt <= 1'b1;
              state         <= OFFER;
            end else begin
              bus.result <= 3'd4;
              bus.deny   <= 1'b1;
              state      <= DENY;
            end
          end else if (bus.MODE == 2'd1 && bus.id_valid) begin
            bus.action_taken <= 2'd3;
            state            <= COMMIT;
          end else begin
            bus.result <= 3'd5;
            fail_cnt   <= fail_nxt;
            bus.locked <= fail_nxt == FW'(MAX_FAILS);
            bus.deny   <= 1'b1;
            state      <= DENY;
          end
        end
        OFFER: begin
          if (bus.user_reject || timer == TW'(OFFER_TIMEOUT - 1)) begin
            bus.offer_alt <= 1'b0;
            bus.result    <= 3'd7;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else if (bus.user_accept) begin
            bus.offer_alt    <= 1'b0;
            bus.action_taken <= 2'd1;
            state            <= COMMIT;
          end else timer <= timer + TW'(1);
        end
        COMMIT: begin
          bus.result       <= bus.action_taken == 2'd2 ? 3'd1 : bus.action_taken == 2'd1 ? 3'd2 : 3'd3;
          bus.action_taken <= 2'd0;
          fail_cnt         <= '0;
          bus.gate_open    <= 1'b1;
          state            <= GATE;
        end
        GATE: begin
          if (timer == TW'(GATE_CYCLES - 1)) begin
            bus.gate_open <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else timer <= timer + TW'(1);
        end
        DENY: begin
          if (timer == TW'(DENY_CYCLES - 1)) begin
            bus.deny <= 1'b0;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else timer <= timer + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parking_gate_controller.sv
// tb_parking_gate_controller: directed scenario tests for the parking gate controller
module tb_parking_gate_controller;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int errors = 0;
  int act_cnt, gate_cnt, deny_cnt, offer_cnt;
  logic [1:0] act_last;
  parking_gate_if bus ();
  parking_gate_controller dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  // per-cycle pulse/level counters sampled away from the active edge
  always @(negedge CLK) begin
    if (bus.action_taken != 2'd0) begin
      act_cnt++;
      act_last = bus.action_taken;
    end
    if (bus.gate_open) gate_cnt++;
    if (bus.deny) deny_cnt++;
    if (bus.offer_alt) offer_cnt++;
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic clr();
    act_cnt = 0; gate_cnt = 0; deny_cnt = 0; offer_cnt = 0; act_last = 2'd0;
  endtask
  task automatic flags(input logic v, input logic s, input logic a, input logic cf, input logic af);
    bus.id_valid = v; bus.id_special = s; bus.adminId_valid = a;
    bus.chosen_flr_full = cf; bus.alternative_flr_full = af;
  endtask
  task automatic submit(input logic [1:0] m, input logic f);
    clr();
    bus.id_submit = 1'b1; bus.mode_sel = m; bus.floor_choice = f;
    tick();
    bus.id_submit = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    for (n = 0; n < 200; n++) begin
      @(negedge CLK);
      if (!bus.busy) break;
    end
    if (n == 200) begin
      errors++;
      $display("FAIL wait_idle: busy still %0b after 200 cycles, required 0", bus.busy);
    end
    tick();
  endtask
  task automatic test_reset();
    #12;
    checks++;
    if ({bus.MODE, bus.action_taken, bus.chosen_flr, bus.gate_open, bus.deny, bus.offer_alt,
         bus.locked, bus.busy, bus.result} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {bus.MODE, bus.action_taken, bus.chosen_flr,
               bus.gate_open, bus.deny, bus.offer_alt, bus.locked, bus.busy, bus.result});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
  endtask
  task automatic test_enter_chosen();
    flags(1, 0, 0, 0, 0);
    submit(2'd0, 1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.action_taken !== 2'd0) begin
      errors++;
      $display("FAIL enter_check_state: busy %b action %0d required 1 and 0", bus.busy, bus.action_taken);
    end
    tick();
    checks++;
    if (bus.action_taken !== 2'd2 || bus.MODE !== 2'd0 || bus.chosen_flr !== 1'b1) begin
      errors++;
      $display("FAIL enter_commit: action %0d MODE %0d flr %b required 2 0 1", bus.action_taken, bus.MODE, bus.chosen_flr);
    end
    wait_idle();
    checks++;
    if (act_cnt !== 1 || gate_cnt !== 8 || bus.result !== 3'd1) begin
      errors++;
      $display("FAIL enter_done: pulses %0d gate %0d result %0d required 1 8 1", act_cnt, gate_cnt, bus.result);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.gate_open !== 1'b0 || bus.MODE !== 2'd0 || bus.chosen_flr !== 1'b1) begin
      errors++;
      $display("FAIL enter_idle: busy %b gate %b MODE %0d flr %b required 0 0 0 1", bus.busy, bus.gate_open, bus.MODE, bus.chosen_flr);
    end
  endtask
  task automatic test_offer_accept();
    flags(1, 0, 0, 1, 0);
    submit(2'd0, 1'b0);
    tick();
    checks++;
    if (bus.offer_alt !== 1'b1) begin
      errors++;
      $display("FAIL offer_raised: offer_alt %b required 1", bus.offer_alt);
    end
    bus.user_accept = 1'b1;
    tick();
    bus.user_accept = 1'b0;
    checks++;
    if (bus.action_taken !== 2'd1 || bus.offer_alt !== 1'b0) begin
      errors++;
      $display("FAIL offer_accept_commit: action %0d offer %b required 1 0", bus.action_taken, bus.offer_alt);
    end
    wait_idle();
    checks++;
    if (act_cnt !== 1 || bus.result !== 3'd2 || gate_cnt !== 8) begin
      errors++;
      $display("FAIL offer_accept_done: pulses %0d result %0d gate %0d required 1 2 8", act_cnt, bus.result, gate_cnt);
    end
  endtask
  task automatic test_offer_timeout();
    flags(1, 0, 0, 1, 0);
    submit(2'd0, 1'b0);
    wait_idle();
    checks++;
    if (offer_cnt !== 16 || bus.result !== 3'd7 || act_cnt !== 0 || gate_cnt !== 0) begin
      errors++;
      $display("FAIL offer_timeout: offer %0d result %0d pulses %0d gate %0d required 16 7 0 0", offer_cnt, bus.result, act_cnt, gate_cnt);
    end
  endtask
  task automatic test_both_full();
    flags(1, 0, 0, 1, 1);
    submit(2'd0, 1'b1);
    wait_idle();
    checks++;
    if (deny_cnt !== 4 || bus.result !== 3'd4 || act_cnt !== 0 || gate_cnt !== 0) begin
      errors++;
      $display("FAIL both_full: deny %0d result %0d pulses %0d gate %0d required 4 4 0 0", deny_cnt, bus.result, act_cnt, gate_cnt);
    end
  endtask
  task automatic test_special();
    flags(0, 1, 0, 1, 1);
    submit(2'd0, 1'b1);
    tick();
    checks++;
    if (bus.action_taken !== 2'd2 || bus.chosen_flr !== 1'b0) begin
      errors++;
      $display("FAIL special_commit: action %0d flr %b required 2 0", bus.action_taken, bus.chosen_flr);
    end
    wait_idle();
    checks++;
    if (act_cnt !== 1 || bus.result !== 3'd1) begin
      errors++;
      $display("FAIL special_done: pulses %0d result %0d required 1 1", act_cnt, bus.result);
    end
  endtask
  task automatic test_exit();
    flags(1, 0, 0, 1, 1);
    submit(2'd1, 1'b1);
    wait_idle();
    checks++;
    if (act_cnt !== 1 || act_last !== 2'd3 || bus.result !== 3'd3 || gate_cnt !== 8 || bus.MODE !== 2'd1) begin
      errors++;
      $display("FAIL exit: pulses %0d code %0d result %0d gate %0d MODE %0d required 1 3 3 8 1", act_cnt, act_last, bus.result, gate_cnt, bus.MODE);
    end
  endtask
  task automatic test_restrict();
    flags(1, 0, 0, 0, 0);
    submit(2'd2, 1'b0);
    wait_idle();
    checks++;
    if (bus.result !== 3'd5 || deny_cnt !== 4 || act_cnt !== 0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL restrict: result %0d deny %0d pulses %0d locked %b required 5 4 0 0", bus.result, deny_cnt, act_cnt, bus.locked);
    end
  endtask
  task automatic test_lockout();
    flags(0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      submit(2'd0, 1'b0);
      wait_idle();
      checks++;
      if (bus.locked !== (i == 3) || bus.result !== 3'd5 || deny_cnt !== 4) begin
        errors++;
        $display("FAIL lockout_invalid_%0d: locked %b result %0d deny %0d required %0b 5 4", i, bus.locked, bus.result, deny_cnt, i == 3);
      end
    end
    flags(1, 0, 0, 0, 0);
    submit(2'd0, 1'b0);
    wait_idle();
    checks++;
    if (bus.result !== 3'd6 || deny_cnt !== 4 || act_cnt !== 0 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL locked_valid: result %0d deny %0d pulses %0d locked %b required 6 4 0 1", bus.result, deny_cnt, act_cnt, bus.locked);
    end
    flags(0, 0, 1, 0, 0);
    submit(2'd2, 1'b0);
    wait_idle();
    checks++;
    if (bus.locked !== 1'b0 || gate_cnt !== 8 || act_cnt !== 0 || bus.result !== 3'd6) begin
      errors++;
      $display("FAIL admin_unlock: locked %b gate %0d pulses %0d result %0d required 0 8 0 6", bus.locked, gate_cnt, act_cnt, bus.result);
    end
  endtask
  task automatic test_busy_ignore();
    flags(1, 0, 0, 0, 0);
    submit(2'd0, 1'b1);
    tick();
    tick();
    bus.id_submit = 1'b1; bus.mode_sel = 2'd1; bus.floor_choice = 1'b0;
    tick();
    bus.id_submit = 1'b0;
    wait_idle();
    tick();
    checks++;
    if (act_cnt !== 1 || gate_cnt !== 8 || bus.MODE !== 2'd0 || bus.chosen_flr !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: pulses %0d gate %0d MODE %0d flr %b busy %b required 1 8 0 1 0", act_cnt, gate_cnt, bus.MODE, bus.chosen_flr, bus.busy);
    end
  endtask
  task automatic test_reset_in_gate();
    flags(1, 0, 0, 0, 0);
    submit(2'd0, 1'b1);
    tick();
    tick();
    checks++;
    if (bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL gate_before_reset: gate %b required 1", bus.gate_open);
    end
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.MODE, bus.action_taken, bus.chosen_flr, bus.gate_open, bus.deny, bus.offer_alt,
         bus.locked, bus.busy, bus.result} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got %b required 0", {bus.MODE, bus.action_taken, bus.chosen_flr,
               bus.gate_open, bus.deny, bus.offer_alt, bus.locked, bus.busy, bus.result});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    tick();
    checks++;
    if (act_cnt !== 1 || bus.busy !== 1'b0 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: pulses %0d busy %b gate %b required 1 0 0", act_cnt, bus.busy, bus.gate_open);
    end
  endtask
  task automatic test_accept_reject();
    flags(1, 0, 0, 1, 0);
    submit(2'd0, 1'b0);
    tick();
    bus.user_accept = 1'b1; bus.user_reject = 1'b1;
    tick();
    bus.user_accept = 1'b0; bus.user_reject = 1'b0;
    checks++;
    if (bus.result !== 3'd7 || bus.offer_alt !== 1'b0 || bus.busy !== 1'b0 || bus.action_taken !== 2'd0) begin
      errors++;
      $display("FAIL accept_reject: result %0d offer %b busy %b action %0d required 7 0 0 0", bus.result, bus.offer_alt, bus.busy, bus.action_taken);
    end
    wait_idle();
    checks++;
    if (act_cnt !== 0 || gate_cnt !== 0) begin
      errors++;
      $display("FAIL accept_reject_quiet: pulses %0d gate %0d required 0 0", act_cnt, gate_cnt);
    end
  endtask
  initial begin
    bus.id_submit = 1'b0; bus.mode_sel = 2'd0; bus.floor_choice = 1'b0;
    bus.user_accept = 1'b0; bus.user_reject = 1'b0;
    flags(0, 0, 0, 0, 0);
    clr();
    test_reset();
    test_enter_chosen();
    test_offer_accept();
    test_offer_timeout();
    test_both_full();
    test_special();
    test_exit();
    test_restrict();
    test_lockout();
    test_busy_ignore();
    test_reset_in_gate();
    test_accept_reject();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
